// File: rtl/hit_trg_count.sv
// Trigger-board rate/health monitor: per-window event counters on trigger strobes
// plus width-qualified pulse monitors on a selectable hit pair and busy line.

module htc_mon #(
   parameter int WIDTH = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic act_i,
   output logic cnt_o,
   output logic err_o
);
   localparam int LW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, ACTIVE, HELD} state_e;

   state_e        state_q, state_d;
   logic [LW-1:0] len_q, len_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
      end
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_o   = 1'b0;
      err_o   = 1'b0;
      case (state_q)
         IDLE: if (act_i) begin
            if (WIDTH <= 1) begin
               cnt_o   = 1'b1;
               state_d = HELD;
            end else begin
               len_d   = LW'(1);
               state_d = ACTIVE;
            end
         end
         ACTIVE: if (act_i) begin
            len_d = len_q + 1'b1;
            if (len_d == LW'(WIDTH)) begin
               cnt_o   = 1'b1;
               state_d = HELD;
            end
         end else begin
            err_o   = 1'b1;
            state_d = IDLE;
         end
         HELD: if (!act_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // window close restarts qualification so a selection change never mixes channels
      if (clr_i) state_d = IDLE;
   end
endmodule

module htc_cnt #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         close_i,
   input  logic [1:0]   inc_i,
   output logic [W-1:0] cnt_o
);
   logic [W-1:0] acc_q, acc_d, out_q, base;
   logic [W:0]   sum;

   // an event in the close cycle belongs to the new window
   always_comb begin
      base  = close_i ? '0 : acc_q;
      sum   = {1'b0, base} + {{(W-1){1'b0}}, inc_i};
      acc_d = sum[W] ? '1 : sum[W-1:0];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_q <= '0;
         out_q <= '0;
      end else begin
         acc_q <= acc_d;
         if (close_i) out_q <= acc_q;
      end
   end

   assign cnt_o = out_q;
endmodule

module hit_trg_count #(
   parameter int   HIT_WIDTH        = 4,
   parameter int   BUSY_WIDTH       = 4,
   parameter logic MONIT_HIT_0_IDLE = 1'b0,
   parameter logic MONIT_HIT_1_IDLE = 1'b0,
   parameter logic MONIT_BUSY_IDLE  = 1'b0
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [7:0]  hit_syn_in,
   input  logic [1:0]  busy_syn_in,
   input  logic        hit_start_in,
   input  logic        update_end_in,
   input  logic        eff_trg_in,
   input  logic        coincid_trg_in,
   input  logic        logic_match_in,
   input  logic        ext_trg_syn_in,
   input  logic [2:0]  hit_monit_fix_sel_in,
   input  logic        busy_monit_fix_sel_in,
   output logic [2:0]  hit_monit_sel_out,
   output logic [7:0]  hit_monit_err_cnt_out,
   output logic [7:0]  busy_monit_err_cnt_out,
   output logic [31:0] hit_monit_cnt_0_out,
   output logic [31:0] hit_monit_cnt_1_out,
   output logic [15:0] busy_monit_cnt_out,
   output logic [15:0] hit_start_cnt_out,
   output logic [15:0] logic_match_cnt_out,
   output logic [15:0] eff_trg_cnt_out,
   output logic [15:0] coincid_trg_cnt_out,
   output logic [15:0] ext_trg_cnt_out
);
   logic       hs_prev_q, lm_prev_q, eff_prev_q, co_prev_q, ext_prev_q, upd_prev_q;
   logic [2:0] sel_q;
   logic       bsel_q;
   logic       close;
   logic       h0_cnt, h0_err, h1_cnt, h1_err, b_cnt, b_err;
   logic       h0_act, h1_act, b_act;

   assign close = update_end_in & ~upd_prev_q;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         hs_prev_q  <= 1'b0;
         lm_prev_q  <= 1'b0;
         eff_prev_q <= 1'b0;
         co_prev_q  <= 1'b0;
         ext_prev_q <= 1'b0;
         upd_prev_q <= 1'b0;
         sel_q      <= '0;
         bsel_q     <= 1'b0;
      end else begin
         hs_prev_q  <= hit_start_in;
         lm_prev_q  <= logic_match_in;
         eff_prev_q <= eff_trg_in;
         co_prev_q  <= coincid_trg_in;
         ext_prev_q <= ext_trg_syn_in;
         upd_prev_q <= update_end_in;
         if (close) begin
            sel_q  <= hit_monit_fix_sel_in;
            bsel_q <= busy_monit_fix_sel_in;
         end
      end
   end

   assign h0_act = hit_syn_in[sel_q] ^ MONIT_HIT_0_IDLE;
   assign h1_act = hit_syn_in[sel_q + 3'd1] ^ MONIT_HIT_1_IDLE;
   assign b_act  = busy_syn_in[bsel_q] ^ MONIT_BUSY_IDLE;
   assign hit_monit_sel_out = sel_q;

   htc_mon #(.WIDTH(HIT_WIDTH)) u_mon_h0 (.clk_i(clk_in), .rst_i(rst_in), .clr_i(close),
      .act_i(h0_act), .cnt_o(h0_cnt), .err_o(h0_err));
   htc_mon #(.WIDTH(HIT_WIDTH)) u_mon_h1 (.clk_i(clk_in), .rst_i(rst_in), .clr_i(close),
      .act_i(h1_act), .cnt_o(h1_cnt), .err_o(h1_err));
   htc_mon #(.WIDTH(BUSY_WIDTH)) u_mon_b (.clk_i(clk_in), .rst_i(rst_in), .clr_i(close),
      .act_i(b_act), .cnt_o(b_cnt), .err_o(b_err));

   htc_cnt #(.W(8)) u_cnt_herr (.clk_i(clk_in), .rst_i(rst_in), .close_i(close),
      .inc_i({h0_err & h1_err, h0_err ^ h1_err}), .cnt_o(hit_monit_err_cnt_out));
   htc_cnt #(.W(8)) u_cnt_berr (.clk_i(clk_in), .rst_i(rst_in), .close_i(close),
      .inc_i({1'b0, b_err}), .cnt_o(busy_monit_err_cnt_out));
   htc_cnt #(.W(32)) u_cnt_h0 (.clk_i(clk_in), .rst_i(rst_in), .close_i(close),
      .inc_i({1'b0, h0_cnt}), .cnt_o(hit_monit_cnt_0_out));
   htc_cnt #(.W(32)) u_cnt_h1 (.clk_i(clk_in), .rst_i(rst_in), .close_i(close),
      .inc_i({1'b0, h1_cnt}), .cnt_o(hit_monit_cnt_1_out));
   htc_cnt #(.W(16)) u_cnt_b (.clk_i(clk_in), .rst_i(rst_in), .close_i(close),
      .inc_i({1'b0, b_cnt}), .cnt_o(busy_monit_cnt_out));
   htc_cnt #(.W(16)) u_cnt_hs (.clk_i(clk_in), .rst_i(rst_in), .close_i(close),
      .inc_i({1'b0, hit_start_in & ~hs_prev_q}), .cnt_o(hit_start_cnt_out));
   htc_cnt #(.W(16)) u_cnt_lm (.clk_i(clk_in), .rst_i(rst_in), .close_i(close),
      .inc_i({1'b0, logic_match_in & ~lm_prev_q}), .cnt_o(logic_match_cnt_out));
   htc_cnt #(.W(16)) u_cnt_eff (.clk_i(clk_in), .rst_i(rst_in), .close_i(close),
      .inc_i({1'b0, eff_trg_in & ~eff_prev_q}), .cnt_o(eff_trg_cnt_out));
   htc_cnt #(.W(16)) u_cnt_co (.clk_i(clk_in), .rst_i(rst_in), .close_i(close),
      .inc_i({1'b0, coincid_trg_in & ~co_prev_q}), .cnt_o(coincid_trg_cnt_out));
   htc_cnt #(.W(16)) u_cnt_ext (.clk_i(clk_in), .rst_i(rst_in), .close_i(close),
      .inc_i({1'b0, ext_trg_syn_in & ~ext_prev_q}), .cnt_o(ext_trg_cnt_out));
endmodule

// File: tb/tb_hit_trg_count.sv
// Directed bench for hit_trg_count: table of single-window scenarios plus
// hand-written sequences for selection, saturation, stuck line and reset.

module tb_hit_trg_count;
   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [7:0]  hit_syn_in;
   logic [1:0]  busy_syn_in;
   logic        hit_start_in, update_end_in, eff_trg_in, coincid_trg_in;
   logic        logic_match_in, ext_trg_syn_in;
   logic [2:0]  hit_monit_fix_sel_in;
   logic        busy_monit_fix_sel_in;
   logic [2:0]  hit_monit_sel_out;
   logic [7:0]  hit_monit_err_cnt_out, busy_monit_err_cnt_out;
   logic [31:0] hit_monit_cnt_0_out, hit_monit_cnt_1_out;
   logic [15:0] busy_monit_cnt_out, hit_start_cnt_out, logic_match_cnt_out;
   logic [15:0] eff_trg_cnt_out, coincid_trg_cnt_out, ext_trg_cnt_out;

   always #10 clk_in = ~clk_in;

   hit_trg_count dut (
      .clk_in(clk_in), .rst_in(rst_in), .hit_syn_in(hit_syn_in), .busy_syn_in(busy_syn_in),
      .hit_start_in(hit_start_in), .update_end_in(update_end_in), .eff_trg_in(eff_trg_in),
      .coincid_trg_in(coincid_trg_in), .logic_match_in(logic_match_in),
      .ext_trg_syn_in(ext_trg_syn_in), .hit_monit_fix_sel_in(hit_monit_fix_sel_in),
      .busy_monit_fix_sel_in(busy_monit_fix_sel_in), .hit_monit_sel_out(hit_monit_sel_out),
      .hit_monit_err_cnt_out(hit_monit_err_cnt_out), .busy_monit_err_cnt_out(busy_monit_err_cnt_out),
      .hit_monit_cnt_0_out(hit_monit_cnt_0_out), .hit_monit_cnt_1_out(hit_monit_cnt_1_out),
      .busy_monit_cnt_out(busy_monit_cnt_out), .hit_start_cnt_out(hit_start_cnt_out),
      .logic_match_cnt_out(logic_match_cnt_out), .eff_trg_cnt_out(eff_trg_cnt_out),
      .coincid_trg_cnt_out(coincid_trg_cnt_out), .ext_trg_cnt_out(ext_trg_cnt_out));

   typedef struct {
      int h0, h1, herr, bcnt, berr, hs, lm, eff, co, ext, sel;
   } exp_t;

   // tgt: 0-7 hit bit, 8-9 busy bit, 10 hit_start, 11 logic_match, 12 eff, 13 coincid, 14 ext
   typedef struct {
      string name;
      int    tgt_a, len_a, n_a;
      int    tgt_b, len_b, n_b;
      exp_t  e;
   } vec_t;

   int   n_chk = 0;
   int   n_fail = 0;
   vec_t tbl [9];
   exp_t z = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
   exp_t e;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input int exp);
      n_chk++;
      if (act !== 32'(exp)) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic check_all(input string nm, input exp_t x);
      check({nm, ".cnt0"}, hit_monit_cnt_0_out, x.h0);
      check({nm, ".cnt1"}, hit_monit_cnt_1_out, x.h1);
      check({nm, ".hit_err"}, 32'(hit_monit_err_cnt_out), x.herr);
      check({nm, ".busy_cnt"}, 32'(busy_monit_cnt_out), x.bcnt);
      check({nm, ".busy_err"}, 32'(busy_monit_err_cnt_out), x.berr);
      check({nm, ".hit_start"}, 32'(hit_start_cnt_out), x.hs);
      check({nm, ".logic_match"}, 32'(logic_match_cnt_out), x.lm);
      check({nm, ".eff"}, 32'(eff_trg_cnt_out), x.eff);
      check({nm, ".coincid"}, 32'(coincid_trg_cnt_out), x.co);
      check({nm, ".ext"}, 32'(ext_trg_cnt_out), x.ext);
      check({nm, ".sel"}, 32'(hit_monit_sel_out), x.sel);
   endtask

   task automatic set_line(input int tgt, input logic v);
      if (tgt < 8)       hit_syn_in[tgt]    = v;
      else if (tgt < 10) busy_syn_in[tgt-8] = v;
      else case (tgt)
         10: hit_start_in   = v;
         11: logic_match_in = v;
         12: eff_trg_in     = v;
         13: coincid_trg_in = v;
         default: ext_trg_syn_in = v;
      endcase
   endtask

   task automatic pulses(input int tgt, input int len, input int n);
      for (int i = 0; i < n; i++) begin
         set_line(tgt, 1'b1);
         repeat (len) tick();
         set_line(tgt, 1'b0);
         repeat (3) tick();
      end
   endtask

   task automatic close_win();
      update_end_in = 1'b1;
      tick();
      update_end_in = 1'b0;
      tick();
   endtask

   initial begin
      rst_in = 1'b1; hit_syn_in = '0; busy_syn_in = '0; hit_start_in = 0; update_end_in = 0;
      eff_trg_in = 0; coincid_trg_in = 0; logic_match_in = 0; ext_trg_syn_in = 0;
      hit_monit_fix_sel_in = '0; busy_monit_fix_sel_in = 1'b0;

      //                name            tA len n   tB len n    h0 h1 he bc be hs lm ef co ex sel
      tbl[0] = '{"hit_qual",         0, 8, 5,   1, 8, 3,  '{5, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
      tbl[1] = '{"hit_glitch",       0, 3, 1,   0, 4, 1,  '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0}};
      tbl[2] = '{"busy_glitch",      8, 3, 1,   8, 4, 1,  '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0}};
      tbl[3] = '{"trig_eff_ext",    12, 1, 7,  14, 2, 2,  '{0, 0, 0, 0, 0, 0, 0, 7, 0, 2, 0}};
      tbl[4] = '{"hit_start_hold",  10, 100, 1, -1, 0, 0, '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0}};
      tbl[5] = '{"lm_coincid",      11, 1, 4,  13, 5, 3,  '{0, 0, 0, 0, 0, 0, 4, 0, 3, 0, 0}};
      tbl[6] = '{"unselected",       2, 8, 2,   9, 8, 2,  '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
      tbl[7] = '{"hit1_glitch",      1, 2, 2,   1, 6, 1,  '{0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0}};
      tbl[8] = '{"exact_width",      0, 4, 3,   8, 5, 1,  '{3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0}};

      repeat (3) tick();
      check_all("reset", z);
      rst_in = 1'b0;
      tick();

      for (int v = 0; v < 9; v++) begin
         pulses(tbl[v].tgt_a, tbl[v].len_a, tbl[v].n_a);
         if (tbl[v].tgt_b >= 0) pulses(tbl[v].tgt_b, tbl[v].len_b, tbl[v].n_b);
         close_win();
         check_all(tbl[v].name, tbl[v].e);
      end

      // selection only takes effect at a close
      hit_monit_fix_sel_in = 3'd1; busy_monit_fix_sel_in = 1'b1;
      pulses(1, 8, 2);
      check("sel_mid_window", 32'(hit_monit_sel_out), 0);
      close_win();
      e = z; e.h1 = 2; e.sel = 1;
      check_all("sel_change", e);
      pulses(1, 8, 1); pulses(2, 8, 3); pulses(9, 4, 1); pulses(8, 8, 1);
      close_win();
      e = z; e.h0 = 1; e.h1 = 3; e.bcnt = 1; e.sel = 1;
      check_all("sel1_window", e);
      hit_monit_fix_sel_in = 3'd7;
      close_win();
      e = z; e.sel = 7;
      check_all("sel7_load", e);
      pulses(7, 8, 1); pulses(0, 8, 2);
      hit_monit_fix_sel_in = 3'd0; busy_monit_fix_sel_in = 1'b0;
      close_win();
      e = z; e.h0 = 1; e.h1 = 2;
      check_all("sel7_wrap", e);

      // saturation on single and dual glitches
      pulses(0, 1, 300);
      close_win();
      e = z; e.herr = 255;
      check_all("err_sat_single", e);
      for (int i = 0; i < 10; i++) begin
         hit_syn_in = 8'h03; tick(); hit_syn_in = 8'h00; tick();
      end
      close_win();
      e = z; e.herr = 20;
      check_all("err_dual", e);
      for (int i = 0; i < 130; i++) begin
         hit_syn_in = 8'h03; tick(); hit_syn_in = 8'h00; tick();
      end
      close_win();
      e = z; e.herr = 255;
      check_all("err_sat_dual", e);

      // line stuck high for a whole window, released at the close
      hit_syn_in[0] = 1'b1;
      repeat (200) tick();
      update_end_in = 1'b1; hit_syn_in[0] = 1'b0;
      tick();
      update_end_in = 1'b0;
      tick();
      e = z; e.h0 = 1;
      check_all("stuck_window", e);
      repeat (10) tick();
      close_win();
      check_all("stuck_next", z);

      // event on the close cycle belongs to the new window
      eff_trg_in = 1'b1; update_end_in = 1'b1;
      tick();
      eff_trg_in = 1'b0; update_end_in = 1'b0;
      tick();
      check_all("close_cycle_old", z);
      close_win();
      e = z; e.eff = 1;
      check_all("close_cycle_new", e);

      // update_end held high closes only once
      pulses(12, 1, 2);
      update_end_in = 1'b1;
      tick();
      pulses(12, 1, 3);
      repeat (10) tick();
      e = z; e.eff = 2;
      check_all("upd_held", e);
      update_end_in = 1'b0;
      tick();
      pulses(12, 1, 1);
      close_win();
      e = z; e.eff = 4;
      check_all("upd_after_hold", e);

      // reset mid-window
      pulses(12, 1, 3);
      close_win();
      e = z; e.eff = 3;
      check_all("pre_reset", e);
      hit_monit_fix_sel_in = 3'd5;
      pulses(12, 1, 2); pulses(0, 8, 1);
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      check_all("reset_mid", z);
      hit_monit_fix_sel_in = 3'd0;
      pulses(12, 1, 2); pulses(0, 8, 1);
      close_win();
      e = z; e.eff = 2; e.h0 = 1;
      check_all("post_reset", e);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/hit_trg_count.md
Name: hit_trg_count

Overview:
Rate/health monitor for the trigger board. It counts events on trigger-path strobes, and qualified pulses on one selected pair of hit lines and one selected busy line. Counting runs over measurement windows closed by update_end_in (nominally 1 ms). At each window close it publishes the window's counts on static output registers for housekeeping readout.

Parameters:
HIT_WIDTH, 4, minimum active length (clocks) for a hit pulse to count; shorter pulses are glitch errors
BUSY_WIDTH, 4, same rule for the busy monitor
MONIT_HIT_0_IDLE, 0, idle level of hit monitor 0 line
MONIT_HIT_1_IDLE, 0, idle level of hit monitor 1 line
MONIT_BUSY_IDLE, 0, idle level of busy monitor line

Ports:
clk_in  in  1  system clock (50 MHz)
rst_in  in  1  synchronous reset, active-high
hit_syn_in  in  8  synchronized hit lines
busy_syn_in  in  2  synchronized busy lines
hit_start_in  in  1  hit-start strobe
update_end_in  in  1  window-close marker; rising edge closes the window
eff_trg_in  in  1  effective trigger
coincid_trg_in  in  1  coincidence trigger
logic_match_in  in  1  logic match
ext_trg_syn_in  in  1  synchronized external trigger
hit_monit_fix_sel_in  in  3  requested hit monitor channel
busy_monit_fix_sel_in  in  1  requested busy monitor channel
hit_monit_sel_out  out  3  active hit monitor selection
hit_monit_err_cnt_out  out  8  glitch errors, both hit monitors combined, last window
busy_monit_err_cnt_out  out  8  busy glitch errors, last window
hit_monit_cnt_0_out  out  32  qualified pulses on hit_syn_in[sel], last window
hit_monit_cnt_1_out  out  32  qualified pulses on hit_syn_in[(sel+1) mod 8], last window
busy_monit_cnt_out  out  16  qualified pulses on busy_syn_in[bsel], last window
hit_start_cnt_out, logic_match_cnt_out, eff_trg_cnt_out, coincid_trg_cnt_out, ext_trg_cnt_out  out  16 each  rising edges of the matching input, last window

Behaviour:
- Reset: all outputs, internal counters, selections and previous-value registers go to 0; monitor state machines go to IDLE.
- Edge detect: one-cycle registered previous value per strobe. An event is counted when input=1 and prev=0. A line held at 1 counts once.
- Monitor state machine, one instance per monitor (hit0, hit1, busy):
  - IDLE: line == idle level. If line != idle, go to ACTIVE with len=1.
  - ACTIVE: len increments while the line stays non-idle. The count increments once, at the cycle len reaches WIDTH; then go to HELD.
  - ACTIVE: if the line returns to idle before len reaches WIDTH, the err counter increments and the state returns to IDLE.
  - HELD: return to IDLE when the line returns to idle. A line stuck non-idle counts once, no error.
  - A pulse of exactly WIDTH cycles counts as valid.
- Window close: the cycle update_end_in rising edge is detected (update_end_in=1, prev=0).
  - Every output count register loads its internal accumulator.
  - Accumulators restart at 0, or at 1 if an event qualifies in that same cycle; that event belongs to the new window.
  - hit_monit_sel_out loads hit_monit_fix_sel_in; the internal busy selection bsel loads busy_monit_fix_sel_in.
  - All three monitor state machines are forced to IDLE, so a selection change never mixes channels.
  - Outputs therefore change one clock after the sampling edge and are stable for the whole next window.
- Selection inputs are ignored between window closes. Before the first close, sel=0 and bsel=0.
- Arithmetic: every accumulator saturates at its all-ones value (8/16/32 bits) and never wraps.
- Err combining: if both hit monitors flag a glitch in the same cycle, hit err increments by 2, with saturation.
- Reset mid-window: the partial window is discarded and outputs read 0 until the next close.
- update_end_in held high generates only one close, on its rising edge.

Test Plan:
- Hit qualification: sel=0; 5 pulses of 8 clocks on hit_syn_in[0], 3 pulses on hit_syn_in[1]; close window -> hit_monit_cnt_0_out=5, hit_monit_cnt_1_out=3, hit_monit_err_cnt_out=0.
- Glitch boundary: one 3-clock pulse and one 4-clock pulse on hit_syn_in[0] -> cnt_0=1, err=1. Same on busy_syn_in[0] with bsel=0 -> busy_monit_cnt_out=1, busy_monit_err_cnt_out=1.
- Selection change: set hit_monit_fix_sel_in=1 mid-window -> hit_monit_sel_out stays 0 until close, then reads 1. The next window monitors hit_syn_in[1] and [2].
- Trigger counters: 7 pulses on eff_trg_in, 2 on ext_trg_syn_in, hit_start_in held high 100 clocks once -> eff_trg_cnt_out=7, ext_trg_cnt_out=2, hit_start_cnt_out=1, others 0.
- Saturation and stuck line: 300 glitches -> hit_monit_err_cnt_out=255. Hit line stuck high for a whole window -> count 1 for that window, 0 for the next.
- Reset: assert rst_in for 1 clock mid-window after several events -> all outputs 0 and sel 0. The next close reports only post-reset events.
